// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the two-master AXI4 read-channel arbiter.
package axi_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [ID_W-1:0]   id;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
  } ar_req_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ID_W-1:0]   id;
    logic [1:0]        resp;
    logic              last;
  } r_rsp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

endpackage

// File: rtl/arb_grant_sel.sv
// Two-way grant picker. Fixed priority (master 1 wins) by default; with
// AXI_ARB_RR_EN defined, a simultaneous request goes to the master that was
// not granted last.
module arb_grant_sel (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic any_req,
  output logic grant
);

`ifndef AXI_ARB_RR_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  // Pick the winning master from the current requests
  always_comb begin
    any_req = req0 | req1;
`ifdef AXI_ARB_RR_EN
    if (req0 && req1) grant = ~last_grant;
    else              grant = req1;
`else
    grant = req1;
`endif
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Two-master, one-slave AXI4 read arbiter: IFU (master 0) and LSU (master 1)
// share one read port with a single outstanding burst.
// Optional macro AXI_ARB_RR_EN enables round-robin on simultaneous requests.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high; valid, once raised, holds with a stable payload until that
// edge. AR ready to the granted master mirrors slave AR ready so both sides
// handshake in the same cycle; R beats pass straight through combinationally.
module axi_read_arbiter
  import axi_arb_pkg::*;
(
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_m0_ar_valid,
  output logic       o_m0_ar_ready,
  input  ar_req_t    i_m0_ar,
  output logic       o_m0_r_valid,
  input  logic       i_m0_r_ready,
  output r_rsp_t     o_m0_r,
  input  logic       i_m1_ar_valid,
  output logic       o_m1_ar_ready,
  input  ar_req_t    i_m1_ar,
  output logic       o_m1_r_valid,
  input  logic       i_m1_r_ready,
  output r_rsp_t     o_m1_r,
  output logic       o_s_ar_valid,
  input  logic       i_s_ar_ready,
  output ar_req_t    o_s_ar,
  input  logic       i_s_r_valid,
  output logic       o_s_r_ready,
  input  r_rsp_t     i_s_r,
  output logic       o_busy,
  output logic       o_protocol_err,
  output arb_state_e o_state
);

  arb_state_e state;
  arb_state_e state_next;
  logic       grant;
  ar_req_t    ar_q;
  logic [7:0] beat_cnt;
  logic [7:0] exp_len;
  logic       perr;
  logic       any_req;
  logic       pick;
  logic       r_hs;
  logic       last_grant;

  arb_grant_sel u_grant_sel (
    .req0       (i_m0_ar_valid),
    .req1       (i_m1_ar_valid),
    .last_grant (last_grant),
    .any_req    (any_req),
    .grant      (pick)
  );

  assign r_hs = i_s_r_valid & o_s_r_ready;

  // State register
  always_ff @(posedge i_clock) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state: one burst at a time, grant re-evaluated only from IDLE
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = ADDR;
      ADDR:    if (i_s_ar_ready) state_next = DATA;
      DATA:    if (r_hs && i_s_r.last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Grant/request latch, beat counting and sticky rlast-position error
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      grant    <= 1'b0;
      ar_q     <= '0;
      beat_cnt <= 8'd0;
      exp_len  <= 8'd0;
      perr     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          grant <= pick;
          ar_q  <= pick ? i_m1_ar : i_m0_ar;
        end
        ADDR: if (i_s_ar_ready) begin
          beat_cnt <= 8'd0;
          exp_len  <= ar_q.len;
        end
        DATA: if (r_hs) begin
          beat_cnt <= beat_cnt + 8'd1;
          if (i_s_r.last ? (beat_cnt != exp_len) : (beat_cnt == exp_len)) perr <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef AXI_ARB_RR_EN
  // Remember who owned the last completed burst
  always_ff @(posedge i_clock) begin
    if (i_reset)                                   last_grant <= 1'b0;
    else if (state == DATA && r_hs && i_s_r.last)  last_grant <= grant;
  end
`else
  assign last_grant = 1'b0;
`endif

  // Outputs: route AR to the slave and R back to the registered grant only
  always_comb begin
    o_s_ar_valid  = (state == ADDR);
    o_s_ar        = ar_q;
    o_m0_ar_ready = (state == ADDR) & ~grant & i_s_ar_ready;
    o_m1_ar_ready = (state == ADDR) &  grant & i_s_ar_ready;
    o_s_r_ready   = (state == DATA) & (grant ? i_m1_r_ready : i_m0_r_ready);
    o_m0_r_valid  = (state == DATA) & ~grant & i_s_r_valid;
    o_m1_r_valid  = (state == DATA) &  grant & i_s_r_valid;
    o_m0_r        = ((state == DATA) && !grant) ? i_s_r : '0;
    o_m1_r        = ((state == DATA) &&  grant) ? i_s_r : '0;
    o_busy        = (state != IDLE);
    o_protocol_err = perr;
    o_state       = state;
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Self-checking bench for axi_read_arbiter with random masters and slave.
module tb_axi_read_arbiter;
  import axi_arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT I/O ----------------
  logic       m_valid [2];
  ar_req_t    m_ar    [2];
  logic       r_ready [2];
  logic       s_ar_ready;
  logic       s_r_valid;
  r_rsp_t     s_r;
  logic       o_m0_ar_ready, o_m1_ar_ready, o_m0_r_valid, o_m1_r_valid;
  r_rsp_t     o_m0_r, o_m1_r;
  logic       o_s_ar_valid, o_s_r_ready, o_busy, o_protocol_err;
  ar_req_t    o_s_ar;
  arb_state_e o_state;

  axi_read_arbiter dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_m0_ar_valid  (m_valid[0]),
    .o_m0_ar_ready  (o_m0_ar_ready),
    .i_m0_ar        (m_ar[0]),
    .o_m0_r_valid   (o_m0_r_valid),
    .i_m0_r_ready   (r_ready[0]),
    .o_m0_r         (o_m0_r),
    .i_m1_ar_valid  (m_valid[1]),
    .o_m1_ar_ready  (o_m1_ar_ready),
    .i_m1_ar        (m_ar[1]),
    .o_m1_r_valid   (o_m1_r_valid),
    .i_m1_r_ready   (r_ready[1]),
    .o_m1_r         (o_m1_r),
    .o_s_ar_valid   (o_s_ar_valid),
    .i_s_ar_ready   (s_ar_ready),
    .o_s_ar         (o_s_ar),
    .i_s_r_valid    (s_r_valid),
    .o_s_r_ready    (o_s_r_ready),
    .i_s_r          (s_r),
    .o_busy         (o_busy),
    .o_protocol_err (o_protocol_err),
    .o_state        (o_state)
  );

  // ---------------- counters ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- stimulus knobs ----------------
  int          req_pct [2];
  int          rrdy_pct, arrdy_pct, rvld_pct, bad_pct;
  int          force_lastpos;
  logic        force_en;
  logic [31:0] force_data;
  logic [1:0]  force_resp;

  // slave model (stimulus side)
  logic       sl_active;
  logic [7:0] sl_len, sl_idx, sl_lastpos;
  logic [3:0] sl_id;

  // handshakes seen at the sampling edge
  logic       h_mar [2];
  logic       h_sar, h_sr;
  logic [7:0] cap_len;
  logic [3:0] cap_id;

  // observed deliveries at masters
  int         rx_cnt  [2];
  int         rx_last_at [2];
  r_rsp_t     last_rx [2];

  // ---------------- reference model (transaction level) ----------------
  logic       mdl_ok, act, ar_sent, own, perr, lg;
  logic [7:0] bidx;
  ar_req_t    cur_ar;
  logic [0:0] grant_q [$];

  function automatic ar_req_t rand_ar();
    ar_req_t a;
    a.addr  = $urandom;
    a.id    = 4'($urandom_range(0, 15));
    a.len   = 8'($urandom_range(0, 7));
    a.size  = 3'd2;
    a.burst = 2'd1;
    return a;
  endfunction

  // Compare DUT outputs with the model, then advance the model by one edge
  task automatic check_cycle();
    logic   e_sarv, e_dat, pick;
    r_rsp_t e_r0, e_r1;
    arb_state_e e_st;
    if (mdl_ok) begin
      e_sarv = act && !ar_sent;
      e_dat  = act && ar_sent;
      e_st   = !act ? IDLE : (ar_sent ? DATA : ADDR);
      e_r0   = (e_dat && own == 1'b0) ? s_r : '0;
      e_r1   = (e_dat && own == 1'b1) ? s_r : '0;
      chk("state", 64'(o_state), 64'(e_st));
      chk("busy", 64'(o_busy), 64'(act));
      chk("protocol_err", 64'(o_protocol_err), 64'(perr));
      chk("s_ar_valid", 64'(o_s_ar_valid), 64'(e_sarv));
      if (e_sarv) chk("s_ar", 64'(o_s_ar), 64'(cur_ar));
      chk("m0_ar_ready", 64'(o_m0_ar_ready), 64'(e_sarv && own == 1'b0 && s_ar_ready));
      chk("m1_ar_ready", 64'(o_m1_ar_ready), 64'(e_sarv && own == 1'b1 && s_ar_ready));
      chk("s_r_ready", 64'(o_s_r_ready), 64'(e_dat && r_ready[own]));
      chk("m0_r_valid", 64'(o_m0_r_valid), 64'(e_dat && own == 1'b0 && s_r_valid));
      chk("m1_r_valid", 64'(o_m1_r_valid), 64'(e_dat && own == 1'b1 && s_r_valid));
      chk("m0_r", 64'(o_m0_r), 64'(e_r0));
      chk("m1_r", 64'(o_m1_r), 64'(e_r1));
    end
    h_mar[0] = m_valid[0] && o_m0_ar_ready;
    h_mar[1] = m_valid[1] && o_m1_ar_ready;
    h_sar    = o_s_ar_valid && s_ar_ready;
    cap_len  = o_s_ar.len;
    cap_id   = o_s_ar.id;
    h_sr     = s_r_valid && o_s_r_ready;
    if (o_m0_r_valid && r_ready[0]) begin
      rx_cnt[0]++; last_rx[0] = o_m0_r;
      if (o_m0_r.last) rx_last_at[0] = rx_cnt[0];
    end
    if (o_m1_r_valid && r_ready[1]) begin
      rx_cnt[1]++; last_rx[1] = o_m1_r;
      if (o_m1_r.last) rx_last_at[1] = rx_cnt[1];
    end
    if (rst) begin
      mdl_ok = 1'b1; act = 1'b0; ar_sent = 1'b0; perr = 1'b0; lg = 1'b0; bidx = 8'd0;
    end else if (mdl_ok) begin
      if (!act) begin
        if (m_valid[0] || m_valid[1]) begin
`ifdef AXI_ARB_RR_EN
          pick = (m_valid[0] && m_valid[1]) ? !lg : m_valid[1];
`else
          pick = m_valid[1];
`endif
          act = 1'b1; own = pick; cur_ar = m_ar[pick]; ar_sent = 1'b0;
        end
      end else if (!ar_sent) begin
        if (s_ar_ready) begin
          ar_sent = 1'b1; bidx = 8'd0; grant_q.push_back(own);
        end
      end else if (s_r_valid && r_ready[own]) begin
        if (s_r.last) begin
          if (bidx != cur_ar.len) perr = 1'b1;
          act = 1'b0; lg = own;
        end else if (bidx == cur_ar.len) begin
          perr = 1'b1;
        end
        bidx = bidx + 8'd1;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive();
    int p;
    if (rst) begin
      m_valid[0] = 1'b0; m_valid[1] = 1'b0; r_ready[0] = 1'b0; r_ready[1] = 1'b0;
      s_ar_ready = 1'b0; s_r_valid = 1'b0; sl_active = 1'b0;
      return;
    end
    for (int i = 0; i < 2; i++) begin
      if (h_mar[i]) m_valid[i] = 1'b0;
      if (!m_valid[i] && req_pct[i] > 0 && $urandom_range(0, 99) < req_pct[i]) begin
        m_valid[i] = 1'b1;
        m_ar[i]    = rand_ar();
      end
      r_ready[i] = ($urandom_range(0, 99) < rrdy_pct);
    end
    s_ar_ready = ($urandom_range(0, 99) < arrdy_pct);
    if (h_sr) begin
      if (s_r.last) sl_active = 1'b0;
      sl_idx    = sl_idx + 8'd1;
      s_r_valid = 1'b0;
    end
    if (h_sar) begin
      sl_active = 1'b1; sl_len = cap_len; sl_id = cap_id; sl_idx = 8'd0;
      if (force_lastpos >= 0) sl_lastpos = 8'(force_lastpos);
      else if ($urandom_range(0, 99) < bad_pct) begin
        p = $urandom_range(0, int'(sl_len) + 1);
        if (p >= int'(sl_len)) p++;
        sl_lastpos = 8'(p);
      end else sl_lastpos = sl_len;
    end
    if (sl_active && !s_r_valid && $urandom_range(0, 99) < rvld_pct) begin
      s_r_valid = 1'b1;
      s_r.data  = force_en ? force_data : $urandom;
      case ($urandom_range(0, 3))
        0, 1:    s_r.resp = AXI_RESP_OKAY;
        2:       s_r.resp = AXI_RESP_SLVERR;
        default: s_r.resp = AXI_RESP_DECERR;
      endcase
      if (force_en) s_r.resp = force_resp;
      s_r.id    = sl_id;
      s_r.last  = (sl_idx == sl_lastpos);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic issue(input int m, input logic [31:0] addr, input logic [7:0] len);
    m_valid[m]     = 1'b1;
    m_ar[m].addr   = addr;
    m_ar[m].id     = 4'(m + 5);
    m_ar[m].len    = len;
    m_ar[m].size   = 3'd2;
    m_ar[m].burst  = 2'd1;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    while ((act || m_valid[0] || m_valid[1]) && n < budget) begin
      cycle();
      n++;
    end
    chk({"wait_", nm}, 64'(!(act || m_valid[0] || m_valid[1])), 64'd1);
  endtask

  task automatic clr_rx();
    for (int i = 0; i < 2; i++) begin
      rx_cnt[i] = 0; rx_last_at[i] = 0; last_rx[i] = '0;
    end
  endtask

  task automatic set_knobs(input int q0, input int q1, input int rr, input int ar, input int rv, input int bad);
    req_pct[0] = q0; req_pct[1] = q1; rrdy_pct = rr; arrdy_pct = ar; rvld_pct = rv; bad_pct = bad;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    mdl_ok = 1'b0; act = 1'b0; ar_sent = 1'b0; own = 1'b0; perr = 1'b0; lg = 1'b0;
    bidx = 8'd0; cur_ar = '0;
    m_valid[0] = 1'b0; m_valid[1] = 1'b0; m_ar[0] = '0; m_ar[1] = '0;
    r_ready[0] = 1'b0; r_ready[1] = 1'b0; s_ar_ready = 1'b0; s_r_valid = 1'b0; s_r = '0;
    sl_active = 1'b0; sl_len = 8'd0; sl_idx = 8'd0; sl_lastpos = 8'd0; sl_id = 4'd0;
    h_mar[0] = 1'b0; h_mar[1] = 1'b0; h_sar = 1'b0; h_sr = 1'b0; cap_len = 8'd0; cap_id = 4'd0;
    force_lastpos = -1; force_en = 1'b0; force_data = 32'd0; force_resp = 2'd0;
    set_knobs(0, 0, 100, 100, 100, 0);
    clr_rx();

    rst = 1'b1;
    repeat (3) cycle();
    rst = 1'b0;
    cycle();
    #1;
    chk("reset_busy", 64'(o_busy), 64'd0);
    chk("reset_err", 64'(o_protocol_err), 64'd0);
    chk("reset_state", 64'(o_state), 64'(IDLE));

    // Lone IFU burst of 4 beats, slave AR ready delayed
    clr_rx();
    set_knobs(0, 0, 100, 0, 100, 0);
    issue(0, 32'h8000_0000, 8'd3);
    repeat (3) cycle();
    arrdy_pct = 100;
    wait_idle("m0_only", 100);
    #1;
    chk("m0_only_beats", 64'(rx_cnt[0]), 64'd4);
    chk("m0_only_last_at", 64'(rx_last_at[0]), 64'd4);
    chk("m0_only_m1_beats", 64'(rx_cnt[1]), 64'd0);
    chk("m0_only_err", 64'(o_protocol_err), 64'd0);

    // Simultaneous requests after an LSU burst
    grant_q.delete();
    issue(1, 32'h0000_4000, 8'd1);
    cycle();
    wait_idle("c_first", 100);
    issue(0, 32'h0000_1000, 8'd2);
    issue(1, 32'h0000_2000, 8'd0);
    cycle();
    wait_idle("c_both", 200);
    chk("c_grant_count", 64'(grant_q.size()), 64'd3);
    chk("c_grant0", 64'(grant_q[0]), 64'd1);
`ifdef AXI_ARB_RR_EN
    chk("c_grant1", 64'(grant_q[1]), 64'd0);
    chk("c_grant2", 64'(grant_q[2]), 64'd1);
`else
    chk("c_grant1", 64'(grant_q[1]), 64'd1);
    chk("c_grant2", 64'(grant_q[2]), 64'd0);
`endif

    // LSU single beat with SLVERR forwarded untouched
    clr_rx();
    force_en = 1'b1; force_data = 32'hDEAD_BEEF; force_resp = AXI_RESP_SLVERR;
    issue(1, 32'h0000_3000, 8'd0);
    cycle();
    wait_idle("slverr", 100);
    force_en = 1'b0;
    #1;
    chk("slverr_beats", 64'(rx_cnt[1]), 64'd1);
    chk("slverr_data", 64'(last_rx[1].data), 64'hDEAD_BEEF);
    chk("slverr_resp", 64'(last_rx[1].resp), 64'd2);
    chk("slverr_last", 64'(last_rx[1].last), 64'd1);
    chk("slverr_err", 64'(o_protocol_err), 64'd0);

    // Master R stall mid-burst
    clr_rx();
    issue(0, 32'h0000_5000, 8'd3);
    n = 0;
    while (!(act && ar_sent && bidx == 8'd1) && n < 50) begin cycle(); n++; end
    chk("stall_reach", 64'(act && ar_sent && bidx == 8'd1), 64'd1);
    rrdy_pct = 0;
    repeat (6) cycle();
    rrdy_pct = 100;
    wait_idle("stall", 100);
    #1;
    chk("stall_beats", 64'(rx_cnt[0]), 64'd4);
    chk("stall_err", 64'(o_protocol_err), 64'd0);

    // Early rlast on the 2nd beat of a 4-beat burst
    clr_rx();
    force_lastpos = 1;
    issue(0, 32'h0000_6000, 8'd3);
    cycle();
    wait_idle("early_last", 100);
    force_lastpos = -1;
    #1;
    chk("early_last_beats", 64'(rx_cnt[0]), 64'd2);
    chk("early_last_err", 64'(o_protocol_err), 64'd1);
    chk("early_last_idle", 64'(o_state), 64'(IDLE));
    repeat (3) cycle();
    #1;
    chk("early_last_sticky", 64'(o_protocol_err), 64'd1);

    // Reset in the middle of a data phase
    rvld_pct = 50;
    issue(0, 32'h0000_7000, 8'd7);
    n = 0;
    while (!(act && ar_sent) && n < 50) begin cycle(); n++; end
    chk("rst_reach_data", 64'(act && ar_sent), 64'd1);
    cycle();
    rst = 1'b1;
    cycle();
    #1;
    chk("midrst_state", 64'(o_state), 64'(IDLE));
    chk("midrst_busy", 64'(o_busy), 64'd0);
    chk("midrst_err", 64'(o_protocol_err), 64'd0);
    chk("midrst_s_ar_valid", 64'(o_s_ar_valid), 64'd0);
    chk("midrst_s_r_ready", 64'(o_s_r_ready), 64'd0);
    chk("midrst_m0_r_valid", 64'(o_m0_r_valid), 64'd0);
    rst = 1'b0;
    cycle();

    // Random traffic, clean slave then slave with misplaced rlast
    set_knobs(30, 30, 70, 50, 70, 0);
    repeat (2500) cycle();
    bad_pct = 15;
    repeat (1500) cycle();
    set_knobs(0, 0, 80, 60, 80, 0);
    wait_idle("drain", 500);
    repeat (2) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
